// File: rtl/npc_pkg.sv
// Shared NPC front-end definitions: reset vector, fetch stride and IFU FSM encoding.
// Used by both the IDU and the IFU.
package npc_pkg;

    localparam logic [63:0] RESET_PC_DEFAULT = 64'h0000_0000_8000_0000;
    localparam logic [63:0] INST_STRIDE      = 64'd4;

    localparam logic [1:0] IFU_REQ  = 2'd0;
    localparam logic [1:0] IFU_WAIT = 2'd1;
    localparam logic [1:0] IFU_HOLD = 2'd2;

    function automatic logic [63:0] align_pc(input logic [63:0] pc);
        return {pc[63:2], 2'b00};
    endfunction

endpackage

// File: rtl/ifu.sv
// Instruction fetch unit: issues one fetch at a time, buffers the returned word for the decoder,
// and follows redirects from any state, discarding responses that belong to the old stream.
module ifu
    import npc_pkg::*;
#(
    parameter logic [63:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    output logic        req_valid,
    output logic [63:0] req_addr,
    input  logic        req_ready,
    input  logic        resp_valid,
    input  logic [31:0] resp_data,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [63:0] inst_pc,
    input  logic        inst_ready,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic [63:0] inst_count
);

    logic [1:0]  r_state;
    logic [63:0] r_pc;
    logic        r_kill;
    logic [31:0] r_inst;
    logic [63:0] r_inst_pc;
    logic [63:0] r_inst_count;

    logic        w_req_hs;
    logic        w_inst_hs;
    logic [63:0] w_redirect_pc;

    assign w_redirect_pc = align_pc(redirect_pc);

    // A redirect cycle never issues a request, so the stale pc cannot leak onto the bus.
    assign req_valid  = (r_state == IFU_REQ) && !redirect_valid && !rst;
    assign req_addr   = r_pc;
    assign inst_valid = (r_state == IFU_HOLD);
    assign inst       = r_inst;
    assign inst_pc    = r_inst_pc;
    assign inst_count = r_inst_count;

    assign w_req_hs  = req_valid && req_ready;
    assign w_inst_hs = inst_valid && inst_ready;

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IFU_REQ;
            r_pc         <= RESET_PC;
            r_kill       <= 1'b0;
            r_inst       <= 32'd0;
            r_inst_pc    <= 64'd0;
            r_inst_count <= 64'd0;
        end else begin
            if (w_inst_hs) begin
                r_inst_count <= r_inst_count + 64'd1;
            end

            if (redirect_valid) begin
                r_pc <= w_redirect_pc;
            end else if (w_inst_hs) begin
                r_pc <= r_pc + INST_STRIDE;
            end

            case (r_state)
                IFU_REQ: begin
                    if (w_req_hs) begin
                        r_state <= IFU_WAIT;
                    end
                end
                IFU_WAIT: begin
                    // Kill marks the in-flight response as belonging to the abandoned stream.
                    if (resp_valid) begin
                        r_kill <= 1'b0;
                        if (redirect_valid || r_kill) begin
                            r_state <= IFU_REQ;
                        end else begin
                            r_inst    <= resp_data;
                            r_inst_pc <= r_pc;
                            r_state   <= IFU_HOLD;
                        end
                    end else if (redirect_valid) begin
                        r_kill <= 1'b1;
                    end
                end
                IFU_HOLD: begin
                    if (redirect_valid || inst_ready) begin
                        r_state <= IFU_REQ;
                    end
                end
                default: begin
                    r_state <= IFU_REQ;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ifu.sv
// Self-checking bench for ifu: directed protocol scenarios followed by randomized traffic,
// with a scoreboard of expected delivered (pc, word) pairs checked by an independent monitor.
module tb_ifu;

    localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic [63:0] req_addr;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        inst_valid;
    logic [31:0] inst;
    logic [63:0] inst_pc;
    logic        inst_ready;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic [63:0] inst_count;

    always #5 clk = ~clk;

    ifu #(.RESET_PC(RST_PC)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_addr      (req_addr),
        .req_ready     (req_ready),
        .resp_valid    (resp_valid),
        .resp_data     (resp_data),
        .inst_valid    (inst_valid),
        .inst          (inst),
        .inst_pc       (inst_pc),
        .inst_ready    (inst_ready),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .inst_count    (inst_count)
    );

    int          n_chk = 0;
    int          n_err = 0;
    logic [63:0] exp_q[$];
    logic [63:0] model_pc;
    logic        pend;
    logic [63:0] pend_addr;
    int          pend_delay;
    int          lat_next;
    int          total_deliv = 0;

    // Monitor history of the previous cycle
    logic [63:0] hs_count = 64'd0;
    logic        p_iv = 1'b0, p_ir = 1'b0, p_rd = 1'b0, p_rv = 1'b0, p_rr = 1'b0;
    logic [31:0] p_inst;
    logic [63:0] p_ipc, p_ra;

    // Instruction memory contents: a fixed word at the reset vector, a hash elsewhere.
    function automatic logic [31:0] mem_word(input logic [63:0] a);
        logic [31:0] h;
        if (a == RST_PC) return 32'h0000_0413;
        h = a[33:2] ^ a[63:32];
        h = h * 32'h9E37_79B1;
        return h ^ 32'h5A5A_0000;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock cycle: drive inputs at negedge, then account for the handshakes of the coming edge.
    task automatic cycle(input logic r, input logic rr, input logic ir,
                         input logic rd, input logic [63:0] rpc);
        logic hs_req, hs_inst;
        @(negedge clk);
        rst            = r;
        req_ready      = rr;
        inst_ready     = ir;
        redirect_valid = rd;
        redirect_pc    = rpc;
        if (r) begin
            pend       = 1'b0;
            resp_valid = 1'b0;
            resp_data  = 32'd0;
        end else if (pend && pend_delay == 0) begin
            resp_valid = 1'b1;
            resp_data  = mem_word(pend_addr);
        end else begin
            resp_valid = 1'b0;
            resp_data  = $urandom;
            if (pend && pend_delay > 0) pend_delay--;
        end
        #3;
        if (r) begin
            model_pc = RST_PC;
            exp_q.delete();
            exp_q.push_back(model_pc);
        end else begin
            hs_req  = req_valid && req_ready;
            hs_inst = inst_valid && inst_ready;
            if (resp_valid) pend = 1'b0;
            if (hs_req) begin
                pend       = 1'b1;
                pend_addr  = req_addr;
                pend_delay = lat_next;
            end
            // Next delivered instruction: redirect target, else sequential successor.
            if (rd) model_pc = {rpc[63:2], 2'b00};
            else if (hs_inst) model_pc = model_pc + 64'd4;
            if (rd || hs_inst) begin
                exp_q.delete();
                exp_q.push_back(model_pc);
            end
        end
    endtask

    // Monitor: scoreboard pops on every delivery handshake, plus protocol stability checks.
    initial begin
        logic [63:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                hs_count = 64'd0;
                p_iv     = 1'b0;
                p_rv     = 1'b0;
            end else begin
                check("inst_count", inst_count, hs_count);
                if (p_iv && !p_ir && !p_rd)
                    check("hold_stable", {inst_valid, inst, inst_pc}, {1'b1, p_inst, p_ipc});
                if (p_rv && !p_rr && !redirect_valid)
                    check("req_stable", {req_valid, req_addr}, {1'b1, p_ra});
                if (req_valid)
                    check("req_align", req_addr[1:0], 2'b00);
                if (inst_valid && inst_ready) begin
                    if (exp_q.size() == 0) begin
                        n_chk++;
                        n_err++;
                        $display("FAIL deliver: got unexpected pc %0h expected no delivery", inst_pc);
                    end else begin
                        e = exp_q.pop_front();
                        check("deliver", {inst_pc, inst}, {e, mem_word(e)});
                    end
                    hs_count++;
                    total_deliv++;
                end
                p_iv   = inst_valid;
                p_ir   = inst_ready;
                p_rd   = redirect_valid;
                p_inst = inst;
                p_ipc  = inst_pc;
                p_rv   = req_valid;
                p_rr   = req_ready;
                p_ra   = req_addr;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; req_ready = 1'b0; resp_valid = 1'b0; resp_data = 32'd0;
        inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 64'd0;
        lat_next = 0; pend = 1'b0; pend_delay = 0; pend_addr = 64'd0; model_pc = RST_PC;

        repeat (3) begin
            cycle(1'b1, 1'b1, 1'b1, 1'b0, 64'd0);
            check("rst_req_valid", req_valid, 1'b0);
            check("rst_state", {inst_valid, inst, inst_pc, inst_count}, '0);
        end

        // Zero-wait fetch from the reset vector
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 64'd0);
        check("c1_req", {req_valid, req_addr}, {1'b1, RST_PC});
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 64'd0);
        check("c2_no_inst", inst_valid, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 64'd0);
        check("c3_inst", {inst_valid, inst, inst_pc}, {1'b1, 32'h0000_0413, RST_PC});

        // Memory not ready for five cycles
        for (int k = 0; k < 5; k++) begin
            cycle(1'b0, 1'b0, 1'b1, 1'b0, 64'd0);
            check("stall_req", {req_valid, req_addr, inst_valid}, {1'b1, RST_PC + 64'd4, 1'b0});
        end
        check("count_after_1", inst_count, 64'd1);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 64'd0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 64'd0);

        // Decoder not ready for four cycles
        for (int k = 0; k < 4; k++) begin
            cycle(1'b0, 1'b1, 1'b0, 1'b0, 64'd0);
            check("hold_stall", {inst_valid, inst_pc, req_valid, inst_count},
                  {1'b1, RST_PC + 64'd4, 1'b0, 64'd1});
        end
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 64'd0);
        check("hold_release", inst_valid, 1'b1);

        // Redirect while waiting: the late response must be dropped
        lat_next = 3;
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 64'd0);
        check("n1_req", {req_valid, req_addr}, {1'b1, RST_PC + 64'd8});
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 64'h0000_0000_8000_1002);
        lat_next = 0;
        for (int k = 0; k < 3; k++) begin
            cycle(1'b0, 1'b1, 1'b1, 1'b0, 64'd0);
            check("kill_no_inst", inst_valid, 1'b0);
        end
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 64'd0);
        check("redir_req", {req_valid, req_addr}, {1'b1, 64'h0000_0000_8000_1000});
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 64'd0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 64'd0);
        check("redir_inst", {inst_valid, inst_pc, inst},
              {1'b1, 64'h0000_0000_8000_1000, mem_word(64'h0000_0000_8000_1000)});

        // Redirect in the same cycle as the response
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 64'd0);
        check("n9_req", {req_valid, req_addr}, {1'b1, 64'h0000_0000_8000_1004});
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 64'h0000_0000_8000_2000);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 64'd0);
        check("same_cycle_redir", {inst_valid, req_valid, req_addr},
              {1'b0, 1'b1, 64'h0000_0000_8000_2000});
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 64'd0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 64'd0);
        check("target_inst", {inst_valid, inst_pc}, {1'b1, 64'h0000_0000_8000_2000});

        // pc wrap at the top of the address space
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 64'd0);
        check("wrap_req", {req_valid, req_addr}, {1'b1, 64'hFFFF_FFFF_FFFF_FFFC});
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 64'd0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 64'd0);
        check("wrap_inst", {inst_valid, inst_pc, inst_count}, {1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 64'd4});
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 64'd0);
        check("wrap_next", {req_valid, req_addr, inst_count}, {1'b1, 64'd0, 64'd5});

        // Redirect in HOLD together with a delivery handshake
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 64'd0);
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 64'h0000_0000_1234_5677);
        check("hold_redir_inst", {inst_valid, inst_pc}, {1'b1, 64'd0});
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 64'd0);
        check("hold_redir_next", {inst_valid, req_valid, req_addr, inst_count},
              {1'b0, 1'b1, 64'h0000_0000_1234_5674, 64'd6});

        // Reset while a response is outstanding
        lat_next = 2;
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 64'd0);
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 64'd0);
        check("midwait_rst", {req_valid, inst_valid, inst_count, inst_pc}, '0);
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 64'd0);
        lat_next = 0;
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 64'd0);
        check("post_rst_req", {req_valid, req_addr}, {1'b1, RST_PC});

        // Randomized traffic
        total_deliv = 0;
        for (int i = 0; i < 3000; i++) begin
            logic        rd;
            logic [63:0] t;
            lat_next = $urandom_range(0, 3);
            rd = ($urandom_range(0, 99) < 6);
            t = {$urandom, $urandom};
            case ($urandom_range(0, 3))
                0: t = {60'hFFFF_FFFF_FFFF_FFF, t[3:0]};
                1: t = RST_PC + {52'd0, t[11:0]};
                default: ;
            endcase
            cycle(1'b0, ($urandom_range(0, 99) < 70), ($urandom_range(0, 99) < 70), rd, t);
        end
        check("random_progress", (total_deliv > 100), 1'b1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
